// File: rtl/dw_result_streamer_if.sv
// Valid/ready pixel stream from the result streamer to the next layer.
interface dw_result_streamer_if #(
    parameter int BITWIDTH = 8
);
    logic                valid;
    logic                ready;
    logic [BITWIDTH-1:0] data;
    logic                last;
    logic                chan_last;

    modport master (output valid, output data, output last, output chan_last, input ready);
    modport slave  (input valid, input data, input last, input chan_last, output ready);
endinterface

// File: rtl/dw_result_streamer.sv
// Requests a frame from the depth-wise conv engine, latches its flattened result
// and streams requantized pixels (shift, optional ReLU, saturate) one per handshake.
module dw_result_streamer #(
    parameter int BITWIDTH                 = 8,
    parameter int IS_BITWIDTH_DOUBLE_SCALE = 1,
    parameter int OUT_IMAGE_WIDTH          = 26,
    parameter int OUT_IMAGE_HEIGHT         = 26,
    parameter int INOUT_CHANNEL            = 1,
    parameter int SHIFT                    = 0,
    parameter int USING_ACTIVATION         = 1,
    parameter int ACTIVATION_IS_RELU       = 1,
    localparam int IN_W  = BITWIDTH * (IS_BITWIDTH_DOUBLE_SCALE + 1),
    localparam int PIX   = OUT_IMAGE_WIDTH * OUT_IMAGE_HEIGHT,
    localparam int N     = INOUT_CHANNEL * PIX,
    localparam int TOTAL = N * IN_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   conv_valid,
    input  logic                   conv_done,
    input  logic [TOTAL-1:0]       conv_result,
    dw_result_streamer_if.master   m,
    output logic                   frame_done
);

    localparam int  IDX_W   = (N > 1) ? $clog2(N) : 1;
    localparam int  PIX_W   = (PIX > 1) ? $clog2(PIX) : 1;
    localparam bit  RELU_ON = (USING_ACTIVATION != 0) && (ACTIVATION_IS_RELU != 0);
    localparam logic signed [IN_W-1:0] MAX_V =
        $signed({{(IN_W-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}});
    localparam logic signed [IN_W-1:0] MIN_V =
        $signed({{(IN_W-BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}});

    typedef enum logic [2:0] {IDLE, REQ, WAIT, STREAM, DONE} state_t;

    state_t              state_q, state_d;
    logic [TOTAL-1:0]    buf_q, buf_d;
    logic [BITWIDTH-1:0] data_q, data_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [PIX_W-1:0]    pix_q, pix_d;
    logic                beat;
    logic                final_beat;

    function automatic logic [BITWIDTH-1:0] requant(input logic [IN_W-1:0] v);
        logic signed [IN_W-1:0] s;
        s = $signed(v) >>> SHIFT;
        if (RELU_ON && s[IN_W-1]) s = '0;
        if (s > MAX_V)      s = MAX_V;
        else if (s < MIN_V) s = MIN_V;
        return s[BITWIDTH-1:0];
    endfunction

    assign beat       = (state_q == STREAM) && m.ready;
    assign final_beat = beat && (idx_q == IDX_W'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = REQ;
            REQ:     state_d = WAIT;
            WAIT:    if (conv_done) state_d = STREAM;
            STREAM:  if (final_beat) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q == REQ) || (state_q == WAIT) || (state_q == STREAM);
        conv_valid = (state_q == REQ) || (state_q == WAIT);
        frame_done = (state_q == DONE);
        m.valid    = (state_q == STREAM);
        m.data     = (state_q == STREAM) ? data_q : '0;
        m.last     = (state_q == STREAM) && (idx_q == IDX_W'(N - 1));
        m.chan_last = (state_q == STREAM) && (pix_q == PIX_W'(PIX - 1));
    end

    // The buffer shifts left each beat so the current pixel is always at the MSBs.
    always_comb begin
        buf_d  = buf_q;
        data_d = data_q;
        idx_d  = idx_q;
        pix_d  = pix_q;
        if ((state_q == WAIT) && conv_done) begin
            buf_d  = conv_result << IN_W;
            data_d = requant(conv_result[TOTAL-1 -: IN_W]);
            idx_d  = '0;
            pix_d  = '0;
        end else if (beat) begin
            buf_d  = buf_q << IN_W;
            data_d = requant(buf_q[TOTAL-1 -: IN_W]);
            idx_d  = final_beat ? '0 : idx_q + IDX_W'(1);
            pix_d  = (pix_q == PIX_W'(PIX - 1)) ? '0 : pix_q + PIX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            idx_q  <= '0;
            pix_q  <= '0;
        end else begin
            data_q <= data_d;
            idx_q  <= idx_d;
            pix_q  <= pix_d;
        end
        buf_q <= buf_d;
    end

endmodule

// File: tb/tb_dw_result_streamer.sv
// Directed bench for dw_result_streamer: 2x2x2 frame with shift/ReLU/saturation,
// plus two 1x1 passthrough instances with ReLU off and on.
module tb_dw_result_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start;
    logic         conv_done;
    logic         busy;
    logic         conv_valid;
    logic         frame_done;
    logic [127:0] conv_result;

    logic         start_p;
    logic         conv_done_p;
    logic [7:0]   conv_result_p;
    logic         busy_p0, conv_valid_p0, frame_done_p0;
    logic         busy_p1, conv_valid_p1, frame_done_p1;

    int check_count = 0;
    int error_count = 0;

    int exp_data [8] = '{4, 64, 0, 1, 127, 0, 1, 0};

    dw_result_streamer_if #(.BITWIDTH(8)) m_if ();
    dw_result_streamer_if #(.BITWIDTH(8)) p0_if ();
    dw_result_streamer_if #(.BITWIDTH(8)) p1_if ();

    dw_result_streamer #(
        .BITWIDTH(8), .IS_BITWIDTH_DOUBLE_SCALE(1),
        .OUT_IMAGE_WIDTH(2), .OUT_IMAGE_HEIGHT(2), .INOUT_CHANNEL(2),
        .SHIFT(2), .USING_ACTIVATION(1), .ACTIVATION_IS_RELU(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .conv_valid(conv_valid), .conv_done(conv_done), .conv_result(conv_result),
        .m(m_if), .frame_done(frame_done)
    );

    dw_result_streamer #(
        .BITWIDTH(8), .IS_BITWIDTH_DOUBLE_SCALE(0),
        .OUT_IMAGE_WIDTH(1), .OUT_IMAGE_HEIGHT(1), .INOUT_CHANNEL(1),
        .SHIFT(0), .USING_ACTIVATION(0), .ACTIVATION_IS_RELU(1)
    ) dut_pass_off (
        .clk(clk), .rst(rst), .start(start_p), .busy(busy_p0),
        .conv_valid(conv_valid_p0), .conv_done(conv_done_p), .conv_result(conv_result_p),
        .m(p0_if), .frame_done(frame_done_p0)
    );

    dw_result_streamer #(
        .BITWIDTH(8), .IS_BITWIDTH_DOUBLE_SCALE(0),
        .OUT_IMAGE_WIDTH(1), .OUT_IMAGE_HEIGHT(1), .INOUT_CHANNEL(1),
        .SHIFT(0), .USING_ACTIVATION(1), .ACTIVATION_IS_RELU(1)
    ) dut_pass_on (
        .clk(clk), .rst(rst), .start(start_p), .busy(busy_p1),
        .conv_valid(conv_valid_p1), .conv_done(conv_done_p), .conv_result(conv_result_p),
        .m(p1_if), .frame_done(frame_done_p1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_conv_valid"}, 32'(conv_valid), 32'd0);
        checkOutput({tag, "_m_valid"}, 32'(m_if.valid), 32'd0);
        checkOutput({tag, "_m_last"}, 32'(m_if.last), 32'd0);
        checkOutput({tag, "_m_chan_last"}, 32'(m_if.chan_last), 32'd0);
        checkOutput({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        checkOutput({tag, "_m_data"}, 32'(m_if.data), 32'd0);
    endtask

    // Runs one frame from a start pulse; called and returns on a negedge.
    task automatic applyStimulus(input int ready_mode, input int done_delay, input int stop_after,
                                 input bit poke_start, input bit start_on_done);
        int         beats;
        int         cycles;
        bit         have_hold;
        bit         rdy;
        logic [7:0] hold_data;
        logic       hold_last;
        logic       hold_cl;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("req_busy", 32'(busy), 32'd1);
        checkOutput("req_conv_valid", 32'(conv_valid), 32'd1);
        checkOutput("req_m_valid", 32'(m_if.valid), 32'd0);
        for (int j = 1; j <= done_delay; j++) begin
            @(negedge clk);
            checkOutput("wait_conv_valid", 32'(conv_valid), 32'd1);
            checkOutput("wait_m_valid", 32'(m_if.valid), 32'd0);
        end
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
        checkOutput("first_conv_valid", 32'(conv_valid), 32'd0);
        checkOutput("first_m_valid", 32'(m_if.valid), 32'd1);
        beats     = 0;
        cycles    = 0;
        have_hold = 1'b0;
        hold_data = '0;
        hold_last = 1'b0;
        hold_cl   = 1'b0;
        while (beats < stop_after && cycles < 100) begin
            rdy = (ready_mode == 0) ? 1'b1 : (cycles % 2 == 0);
            m_if.ready = rdy;
            start = poke_start && (cycles == 2);
            checkOutput("stream_busy", 32'(busy), 32'd1);
            checkOutput("stream_m_valid", 32'(m_if.valid), 32'd1);
            if (m_if.valid) begin
                if (have_hold) begin
                    checkOutput("hold_data", 32'(m_if.data), 32'(hold_data));
                    checkOutput("hold_last", 32'(m_if.last), 32'(hold_last));
                    checkOutput("hold_chan_last", 32'(m_if.chan_last), 32'(hold_cl));
                end
                if (rdy) begin
                    checkOutput($sformatf("beat%0d_data", beats), 32'(m_if.data), 32'(exp_data[beats]));
                    checkOutput($sformatf("beat%0d_chan_last", beats), 32'(m_if.chan_last), 32'(beats % 4 == 3));
                    checkOutput($sformatf("beat%0d_last", beats), 32'(m_if.last), 32'(beats == 7));
                    beats++;
                    have_hold = 1'b0;
                end else begin
                    have_hold = 1'b1;
                    hold_data = m_if.data;
                    hold_last = m_if.last;
                    hold_cl   = m_if.chan_last;
                end
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        if (beats < stop_after) checkOutput("beat_timeout", 32'(beats), 32'(stop_after));
        if (stop_after == 8) begin
            checkOutput("done_frame_done", 32'(frame_done), 32'd1);
            checkOutput("done_busy", 32'(busy), 32'd0);
            checkOutput("done_m_valid", 32'(m_if.valid), 32'd0);
            checkOutput("done_m_last", 32'(m_if.last), 32'd0);
            m_if.ready = 1'b1;
            start = start_on_done;
            @(negedge clk);
            start = 1'b0;
            checkIdle("after_done");
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        conv_done     = 1'b0;
        m_if.ready    = 1'b1;
        p0_if.ready   = 1'b1;
        p1_if.ready   = 1'b1;
        start_p       = 1'b0;
        conv_done_p   = 1'b0;
        conv_result_p = 8'h80;
        conv_result   = 128'h0010_0100_FFF0_0007_7FFF_8000_0004_0003;

        repeat (2) @(negedge clk);
        checkIdle("reset");
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] conv_done while idle");
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
        checkIdle("idle_done_pulse");
        @(negedge clk);
        checkIdle("idle_done_pulse2");

        $display("[TB] basic frame");
        applyStimulus(0, 3, 8, 1'b0, 1'b0);

        $display("[TB] backpressure frame");
        applyStimulus(1, 3, 8, 1'b0, 1'b0);

        $display("[TB] long wait with start poked during stream");
        applyStimulus(1, 20, 8, 1'b1, 1'b0);

        $display("[TB] reset mid-stream");
        applyStimulus(0, 3, 3, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checkIdle("mid_reset");
        rst = 1'b0;
        @(negedge clk);
        checkIdle("post_reset");
        applyStimulus(0, 3, 8, 1'b0, 1'b0);

        $display("[TB] back-to-back frames");
        applyStimulus(0, 1, 8, 1'b0, 1'b1);
        applyStimulus(0, 2, 8, 1'b0, 1'b0);

        $display("[TB] passthrough");
        start_p = 1'b1;
        @(negedge clk);
        start_p = 1'b0;
        @(negedge clk);
        conv_done_p = 1'b1;
        @(negedge clk);
        conv_done_p = 1'b0;
        checkOutput("pass_off_valid", 32'(p0_if.valid), 32'd1);
        checkOutput("pass_off_data", 32'(p0_if.data), 32'h80);
        checkOutput("pass_off_last", 32'(p0_if.last), 32'd1);
        checkOutput("pass_off_chan_last", 32'(p0_if.chan_last), 32'd1);
        checkOutput("pass_on_valid", 32'(p1_if.valid), 32'd1);
        checkOutput("pass_on_data", 32'(p1_if.data), 32'h00);
        @(negedge clk);
        checkOutput("pass_off_frame_done", 32'(frame_done_p0), 32'd1);
        checkOutput("pass_on_frame_done", 32'(frame_done_p1), 32'd1);
        @(negedge clk);
        checkOutput("pass_off_idle_busy", 32'(busy_p0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
